// File: rtl/matrix_scan_ctrl_if.sv
// Host-side bundle for matrix_scan_ctrl: back-bank write port, swap request, and panel scan outputs.
// master = host/bench, slave = controller.
interface matrix_scan_ctrl_if #(
    parameter int unsigned ROWS = 16,
    parameter int unsigned ID_W = 5
);
    logic [ID_W-1:0] column_id;
    logic [ROWS-1:0] in_column;
    logic            LOAD;
    logic            IN_CLR;
    logic            SWAP;
    logic [ID_W-1:0] column_seg;
    logic [ROWS-1:0] out_column;
    logic            COLUMN_CLK;
    logic            OUT_CLR;
    logic            frame_done;
    logic            swap_pending;

    modport master (
        output column_id, in_column, LOAD, IN_CLR, SWAP,
        input  column_seg, out_column, COLUMN_CLK, OUT_CLR, frame_done, swap_pending
    );

    modport slave (
        input  column_id, in_column, LOAD, IN_CLR, SWAP,
        output column_seg, out_column, COLUMN_CLK, OUT_CLR, frame_done, swap_pending
    );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Double-buffered LED column-scan controller: host fills the back bank, the front bank is scanned
// as BLANK/SHOW phases per column, and banks exchange only at a frame boundary.
module matrix_scan_ctrl #(
    parameter int unsigned ROWS      = 16,
    parameter int unsigned COLS      = 32,
    parameter int unsigned ID_W      = 5,
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned DWELL_CYC = 8
) (
    input logic               CLK,
    input logic               RESET,
    matrix_scan_ctrl_if.slave bus
);

    localparam int unsigned PhMax = (BLANK_CYC > DWELL_CYC) ? BLANK_CYC : DWELL_CYC;
    localparam int unsigned PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;

    localparam logic [0:0] StBlank = 1'b0;
    localparam logic [0:0] StShow  = 1'b1;

    logic [1:0][COLS-1:0][ROWS-1:0] bank_q, bank_d;
    logic                           bank_sel_q, bank_sel_d;
    logic                           swap_pending_q, swap_pending_d;

    // Scan position runs one cycle ahead of the registered outputs it produces.
    logic [0:0]      state_q, state_d;
    logic [PhW-1:0]  phase_q, phase_d;
    logic [ID_W-1:0] seg_q, seg_d;

    logic [ID_W-1:0] column_seg_q;
    logic [ROWS-1:0] out_column_q, out_column_d, front_col;
    logic            column_clk_q, out_clr_q, frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q + 1'b1;
        seg_d        = seg_q;
        frame_done_d = 1'b0;
        case (state_q)
            StBlank: begin
                if (phase_q == PhW'(BLANK_CYC - 1)) begin
                    state_d = StShow;
                    phase_d = '0;
                end
            end
            default: begin
                if (phase_q == PhW'(DWELL_CYC - 1)) begin
                    state_d      = StBlank;
                    phase_d      = '0;
                    seg_d        = (seg_q == ID_W'(COLS - 1)) ? '0 : seg_q + 1'b1;
                    frame_done_d = (seg_q == ID_W'(COLS - 1));
                end
            end
        endcase
    end

    always_comb begin
        front_col = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            if (seg_q == ID_W'(c)) begin
                front_col = bank_q[bank_sel_q][c];
            end
        end
        out_column_d = (state_q == StShow) ? front_col : '0;
    end

    // Writes target the pre-edge back bank; out-of-range column_id never matches a column.
    always_comb begin
        bank_d = bank_q;
        for (int c = 0; c < int'(COLS); c++) begin
            if (bus.IN_CLR) begin
                bank_d[~bank_sel_q][c] = '0;
            end else if (bus.LOAD && (bus.column_id == ID_W'(c))) begin
                bank_d[~bank_sel_q][c] = bus.in_column;
            end
        end
    end

    // frame_done_q marks the visible last cycle of the frame, so the exchange lands on its edge.
    always_comb begin
        bank_sel_d     = bank_sel_q;
        swap_pending_d = swap_pending_q | bus.SWAP;
        if (frame_done_q && (swap_pending_q || bus.SWAP)) begin
            bank_sel_d     = ~bank_sel_q;
            swap_pending_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bank_q         <= '0;
            bank_sel_q     <= 1'b0;
            swap_pending_q <= 1'b0;
            state_q        <= StBlank;
            phase_q        <= '0;
            seg_q          <= '0;
            column_seg_q   <= '0;
            out_column_q   <= '0;
            column_clk_q   <= 1'b0;
            out_clr_q      <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            bank_q         <= bank_d;
            bank_sel_q     <= bank_sel_d;
            swap_pending_q <= swap_pending_d;
            state_q        <= state_d;
            phase_q        <= phase_d;
            seg_q          <= seg_d;
            column_seg_q   <= seg_q;
            out_column_q   <= out_column_d;
            column_clk_q   <= (state_q == StBlank) && (phase_q == '0);
            out_clr_q      <= (state_q == StBlank);
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.column_seg   = column_seg_q;
    assign bus.out_column   = out_column_q;
    assign bus.COLUMN_CLK   = column_clk_q;
    assign bus.OUT_CLR      = out_clr_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.swap_pending = swap_pending_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: positional scan model plus two-bank frame store.
module tb_matrix_scan_ctrl;

    localparam int ROWS      = 16;
    localparam int COLS      = 32;
    localparam int ID_W      = 6;
    localparam int BLANK_CYC = 2;
    localparam int DWELL_CYC = 8;
    localparam int COLP      = BLANK_CYC + DWELL_CYC;
    localparam int FRAMEP    = COLS * COLP;
    localparam int OW        = ID_W + ROWS + 4;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    matrix_scan_ctrl_if #(.ROWS(ROWS), .ID_W(ID_W)) bus ();

    matrix_scan_ctrl #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .ID_W      (ID_W),
        .BLANK_CYC (BLANK_CYC),
        .DWELL_CYC (DWELL_CYC)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ROWS-1:0] m_bank [2][COLS];
    int              m_sel;
    bit              m_pend;
    int              m_k;  // visible cycle index since reset release, -1 before the first edge

    function automatic void model_reset();
        foreach (m_bank[b, c]) m_bank[b][c] = '0;
        m_sel  = 0;
        m_pend = 1'b0;
        m_k    = -1;
    endfunction

    function automatic logic [OW-1:0] expv();
        int              col;
        int              ph;
        logic [ROWS-1:0] d;
        if (m_k < 0) return {ID_W'(0), ROWS'(0), 1'b0, 1'b1, 1'b0, m_pend};
        col = (m_k / COLP) % COLS;
        ph  = m_k % COLP;
        d   = (ph >= BLANK_CYC) ? m_bank[m_sel][col] : '0;
        return {ID_W'(col), d, ph == 0, ph < BLANK_CYC, (m_k % FRAMEP) == FRAMEP - 1, m_pend};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {bus.column_seg, bus.out_column, bus.COLUMN_CLK, bus.OUT_CLR, bus.frame_done,
                bus.swap_pending};
    endfunction

    function automatic void model_edge();
        bit bnd;
        int back;
        bnd  = (m_k >= 0) && ((m_k % FRAMEP) == FRAMEP - 1);
        back = 1 - m_sel;
        if (bus.IN_CLR) begin
            for (int c = 0; c < COLS; c++) m_bank[back][c] = '0;
        end else if (bus.LOAD && (int'(bus.column_id) < COLS)) begin
            m_bank[back][bus.column_id] = bus.in_column;
        end
        if (bnd && (m_pend || bus.SWAP)) begin
            m_sel  = 1 - m_sel;
            m_pend = 1'b0;
        end else begin
            m_pend = m_pend | bus.SWAP;
        end
        m_k++;
    endfunction

    task automatic step();
        @(posedge CLK);
        if (RESET) model_edge();
        #1;
    endtask

    task automatic set_in(input logic load, input logic clr, input logic swp,
                          input logic [ID_W-1:0] id, input logic [ROWS-1:0] d);
        bus.LOAD      = load;
        bus.IN_CLR    = clr;
        bus.SWAP      = swp;
        bus.column_id = id;
        bus.in_column = d;
    endtask

    task automatic test_reset();
        logic [OW-1:0] rst_val;
        rst_val = {ID_W'(0), ROWS'(0), 1'b0, 1'b1, 1'b0, 1'b0};
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        model_reset();
        step();
        n_cmp++;
        if (obs() !== rst_val) begin
            n_bad++;
            $display("FAIL reset_values got=%h exp=%h", obs(), rst_val);
        end
        @(negedge CLK) RESET = 1'b1;
        step();
        n_cmp++;
        if (bus.COLUMN_CLK !== 1'b1 || bus.OUT_CLR !== 1'b1 || bus.column_seg !== '0) begin
            n_bad++;
            $display("FAIL first_edge got clk=%b clr=%b seg=%0d exp 1 1 0",
                     bus.COLUMN_CLK, bus.OUT_CLR, bus.column_seg);
        end
        for (int i = 0; i < 2 * FRAMEP + 5; i++) begin
            step();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL idle_scan k=%0d got=%h exp=%h", m_k, obs(), expv());
            end
        end
    endtask

    task automatic test_double_buffer();
        int hits;
        set_in(1'b1, 1'b0, 1'b0, ID_W'(5), 16'hA5A5);
        step();
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3 * FRAMEP; i++) begin
            step();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL no_swap_hidden k=%0d got=%h exp=%h", m_k, obs(), expv());
            end
        end
        set_in(1'b0, 1'b0, 1'b1, '0, '0);
        step();
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (bus.swap_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL swap_pending_set got=%b exp=1", bus.swap_pending);
        end
        for (int i = 0; i <= FRAMEP && (m_k % FRAMEP) != FRAMEP - 1; i++) begin
            step();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL swap_wait k=%0d got=%h exp=%h", m_k, obs(), expv());
            end
        end
        hits = 0;
        for (int i = 0; i < FRAMEP; i++) begin
            step();
            if (bus.out_column === 16'hA5A5) hits++;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL swapped_frame k=%0d got=%h exp=%h", m_k, obs(), expv());
            end
        end
        n_cmp++;
        if (hits !== DWELL_CYC) begin
            n_bad++;
            $display("FAIL a5a5_dwell got=%0d exp=%0d", hits, DWELL_CYC);
        end
    endtask

    task automatic test_swap_clear();
        set_in(1'b1, 1'b1, 1'b0, ID_W'(5), 16'hFFFF);
        step();
        set_in(1'b0, 1'b0, 1'b1, '0, '0);
        step();
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 2 * FRAMEP; i++) begin
            step();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL clear_wins k=%0d got=%h exp=%h", m_k, obs(), expv());
            end
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i <= FRAMEP && (m_k % FRAMEP) != FRAMEP - 1; i++) begin
            step();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL boundary_wait k=%0d got=%h exp=%h", m_k, obs(), expv());
            end
        end
        n_cmp++;
        if (bus.frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL boundary_frame_done got=%b exp=1", bus.frame_done);
        end
        set_in(1'b1, 1'b0, 1'b1, ID_W'(0), 16'h0001);
        step();
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < BLANK_CYC; i++) step();
        n_cmp++;
        if (bus.out_column !== 16'h0001 || bus.swap_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL boundary_collision got=%h/%b exp=0001/0", bus.out_column,
                     bus.swap_pending);
        end
        for (int i = 0; i < FRAMEP; i++) begin
            step();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL boundary_frame k=%0d got=%h exp=%h", m_k, obs(), expv());
            end
        end
    endtask

    task automatic test_range_repeat();
        logic [ROWS-1:0] d31;
        d31 = ROWS'($urandom_range(1, 16'hFFFF));
        set_in(1'b1, 1'b0, 1'b0, ID_W'(31), d31);
        step();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 1'b0, ID_W'($urandom_range(COLS, (1 << ID_W) - 1)),
                   ROWS'($urandom));
            step();
        end
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3 * FRAMEP; i++) begin
            if ((m_k % FRAMEP) == 30 || (m_k % FRAMEP) == 150 || (m_k % FRAMEP) == 260) begin
                bus.SWAP = 1'b1;
            end
            step();
            bus.SWAP = 1'b0;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL range_repeat k=%0d got=%h exp=%h", m_k, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3 * FRAMEP; i++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
                   $urandom_range(0, 90) == 0, ID_W'($urandom), ROWS'($urandom));
            step();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL random k=%0d got=%h exp=%h", m_k, obs(), expv());
            end
        end
        set_in(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] rst_val;
        int            lit;
        rst_val = {ID_W'(0), ROWS'(0), 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i <= 2 * FRAMEP && (m_k % FRAMEP) != 17 * COLP + 4; i++) begin
            if ((m_k % FRAMEP) == 10) bus.SWAP = 1'b1;
            step();
            bus.SWAP = 1'b0;
        end
        n_cmp++;
        if (bus.column_seg !== ID_W'(17) || bus.OUT_CLR !== 1'b0 || bus.swap_pending !== 1'b1)
        begin
            n_bad++;
            $display("FAIL pre_reset_pos got seg=%0d clr=%b pend=%b exp 17 0 1",
                     bus.column_seg, bus.OUT_CLR, bus.swap_pending);
        end
        #2 RESET = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== rst_val) begin
            n_bad++;
            $display("FAIL async_reset got=%h exp=%h", obs(), rst_val);
        end
        model_reset();
        step();
        step();
        @(negedge CLK) RESET = 1'b1;
        lit = 0;
        for (int i = 0; i < 2 * FRAMEP + 3; i++) begin
            if (i == 15) bus.SWAP = 1'b1;
            step();
            bus.SWAP = 1'b0;
            if (bus.out_column !== '0) lit++;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL after_reset k=%0d got=%h exp=%h", m_k, obs(), expv());
            end
        end
        n_cmp++;
        if (lit !== 0) begin
            n_bad++;
            $display("FAIL banks_cleared got=%0d lit cycles exp=0", lit);
        end
    endtask

    initial begin
        test_reset();
        test_double_buffer();
        test_swap_clear();
        test_boundary();
        test_range_repeat();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
